// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the three SDRAM masters, the port arbiter and the SDRAM controller.
// slave = arbiter view; master = view of the masters plus controller around it.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic                  m0_rd_req;
    logic [ADDR_W-1:0]     m0_addr;
    logic                  m0_done;

    logic                  m1_rd_req;
    logic                  m1_wr_req;
    logic [ADDR_W-1:0]     m1_addr;
    logic [4*DATA_W-1:0]   m1_wr_data;
    logic                  m1_done;

    logic                  m2_rd_req;
    logic                  m2_wr_req;
    logic [ADDR_W-1:0]     m2_addr;
    logic [4*DATA_W-1:0]   m2_wr_data;
    logic                  m2_done;

    logic [4*DATA_W-1:0]   rd_data;

    logic                  sdram_rd_req;
    logic                  sdram_wr_req;
    logic [ADDR_W-1:0]     sdram_addr;
    logic [4*DATA_W-1:0]   sdram_wr_data;
    logic                  sdram_rd_done;
    logic                  sdram_wr_done;
    logic [4*DATA_W-1:0]   sdram_rd_data;

    logic                  err;
    logic [1:0]            grant;

    modport slave (
        input  m0_rd_req, m0_addr,
        input  m1_rd_req, m1_wr_req, m1_addr, m1_wr_data,
        input  m2_rd_req, m2_wr_req, m2_addr, m2_wr_data,
        input  sdram_rd_done, sdram_wr_done, sdram_rd_data,
        output m0_done, m1_done, m2_done, rd_data,
        output sdram_rd_req, sdram_wr_req, sdram_addr, sdram_wr_data,
        output err, grant
    );

    modport master (
        output m0_rd_req, m0_addr,
        output m1_rd_req, m1_wr_req, m1_addr, m1_wr_data,
        output m2_rd_req, m2_wr_req, m2_addr, m2_wr_data,
        output sdram_rd_done, sdram_wr_done, sdram_rd_data,
        input  m0_done, m1_done, m2_done, rd_data,
        input  sdram_rd_req, sdram_wr_req, sdram_addr, sdram_wr_data,
        input  err, grant
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-master arbiter for the single 4-word-burst SDRAM controller port (M0 fixed priority, M1/M2 round-robin).
// Optional BUSY watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | pick a winner, latch its address/data/direction
// BUSY  | controller request held until the matching done
// DONE  | one-cycle done pulse to the owner, round-robin update
// GAP   | idle cycle so the owner can drop its request
module sdram_port_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    sdram_port_arbiter_if.slave bus
);
    localparam int BW = 4*DATA_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, GAP} state_t;

    state_t            state, state_nxt;
    logic              rd_q, rd_nxt;
    logic              wr_q, wr_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [BW-1:0]     wd_q, wd_nxt;
    logic [BW-1:0]     rdata_q, rdata_nxt;
    logic [2:0]        done_q, done_nxt;
    logic              err_q, err_nxt;
    logic [1:0]        grant_q, grant_nxt;
    logic              rr_q, rr_nxt;        // 1: M2 was served last

    logic              sel_valid;
    logic [1:0]        sel;
    logic              sel_rd, sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [BW-1:0]     sel_wd;
    logic              m1_any, m2_any;
    logic [2:0]        owner_oh;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]       tmr_q, tmr_nxt;
`else
    logic              unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign m1_any = bus.m1_rd_req | bus.m1_wr_req;
    assign m2_any = bus.m2_rd_req | bus.m2_wr_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            grant_q <= 2'd3;
            rr_q    <= 1'b1;
`ifdef SDRAM_ARB_TIMEOUT_EN
            tmr_q   <= '0;
`endif
        end else begin
            state   <= state_nxt;
            rd_q    <= rd_nxt;
            wr_q    <= wr_nxt;
            addr_q  <= addr_nxt;
            wd_q    <= wd_nxt;
            rdata_q <= rdata_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            grant_q <= grant_nxt;
            rr_q    <= rr_nxt;
`ifdef SDRAM_ARB_TIMEOUT_EN
            tmr_q   <= tmr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        rd_nxt    = rd_q;
        wr_nxt    = wr_q;
        addr_nxt  = addr_q;
        wd_nxt    = wd_q;
        rdata_nxt = rdata_q;
        done_nxt  = '0;
        err_nxt   = err_q;
        grant_nxt = grant_q;
        rr_nxt    = rr_q;
        sel_valid = 1'b0;
        sel       = 2'd3;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wd    = '0;
        owner_oh  = '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
        tmr_nxt   = tmr_q;
`endif

        case (grant_q)
            2'd0:    owner_oh = 3'b001;
            2'd1:    owner_oh = 3'b010;
            2'd2:    owner_oh = 3'b100;
            default: owner_oh = 3'b000;
        endcase

        case (state)
            IDLE: begin
                if (bus.m0_rd_req) begin
                    sel_valid = 1'b1;
                    sel       = 2'd0;
                    sel_rd    = 1'b1;
                    sel_addr  = bus.m0_addr;
                end else if (m1_any && (!m2_any || rr_q)) begin
                    sel_valid = 1'b1;
                    sel       = 2'd1;
                    sel_rd    = bus.m1_rd_req;
                    sel_wr    = bus.m1_wr_req;
                    sel_addr  = bus.m1_addr;
                    sel_wd    = bus.m1_wr_data;
                end else if (m2_any) begin
                    sel_valid = 1'b1;
                    sel       = 2'd2;
                    sel_rd    = bus.m2_rd_req;
                    sel_wr    = bus.m2_wr_req;
                    sel_addr  = bus.m2_addr;
                    sel_wd    = bus.m2_wr_data;
                end
                if (sel_valid) begin
                    // Conflicting direction resolves to a write; misalignment is truncated to the burst boundary.
                    rd_nxt    = sel_rd & ~sel_wr;
                    wr_nxt    = sel_wr;
                    addr_nxt  = {sel_addr[ADDR_W-1:2], 2'b00};
                    wd_nxt    = sel_wd;
                    grant_nxt = sel;
                    err_nxt   = err_q | (sel_rd & sel_wr) | (|sel_addr[1:0]);
                    state_nxt = BUSY;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    tmr_nxt   = TMR_LOAD;
`endif
                end
            end
            BUSY: begin
                if (rd_q && bus.sdram_rd_done) begin
                    rd_nxt    = 1'b0;
                    rdata_nxt = bus.sdram_rd_data;
                    done_nxt  = owner_oh;
                    state_nxt = DONE;
                end else if (wr_q && bus.sdram_wr_done) begin
                    wr_nxt    = 1'b0;
                    done_nxt  = owner_oh;
                    state_nxt = DONE;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    done_nxt  = owner_oh;
                    state_nxt = DONE;
                end else begin
                    tmr_nxt   = tmr_q - 16'd1;
                end
`endif
            end
            DONE: begin
                if (grant_q == 2'd1) rr_nxt = 1'b0;
                if (grant_q == 2'd2) rr_nxt = 1'b1;
                grant_nxt = 2'd3;
                state_nxt = GAP;
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.sdram_rd_req  = rd_q;
    assign bus.sdram_wr_req  = wr_q;
    assign bus.sdram_addr    = addr_q;
    assign bus.sdram_wr_data = wd_q;
    assign bus.rd_data       = rdata_q;
    assign bus.m0_done       = done_q[0];
    assign bus.m1_done       = done_q[1];
    assign bus.m2_done       = done_q[2];
    assign bus.err           = err_q;
    assign bus.grant         = grant_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: vector table of single transactions plus hand sequences.
module tb_sdram_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) bus ();

    sdram_port_arbiter #(.ADDR_W(24), .DATA_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        m0_rd;
        logic        m1_rd;
        logic        m1_wr;
        logic        m2_rd;
        logic        m2_wr;
        logic [23:0] m0_addr;
        logic [23:0] m1_addr;
        logic [23:0] m2_addr;
        logic [63:0] m1_wd;
        logic [63:0] m2_wd;
        int          lat;
        logic [63:0] ctl_rd;
        logic [1:0]  exp_grant;
        logic        exp_rd;
        logic        exp_wr;
        logic [23:0] exp_addr;
        logic [63:0] exp_wd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.m0_rd_req = 0; bus.m0_addr = '0;
        bus.m1_rd_req = 0; bus.m1_wr_req = 0; bus.m1_addr = '0; bus.m1_wr_data = '0;
        bus.m2_rd_req = 0; bus.m2_wr_req = 0; bus.m2_addr = '0; bus.m2_wr_data = '0;
        bus.sdram_rd_done = 0; bus.sdram_wr_done = 0; bus.sdram_rd_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [2:0] dones();
        return {bus.m2_done, bus.m1_done, bus.m0_done};
    endfunction

    // Called in the first BUSY cycle; returns in the GAP cycle.
    task automatic serve(input int lat, input logic is_rd, input logic [63:0] rdata, input logic [1:0] owner);
        logic [2:0] exp_d;
        exp_d = 3'b001 << owner;
        for (int i = 1; i < lat; i++) begin
            chk("busy_no_done", 64'(dones()), 64'd0);
            tick();
        end
        chk("held_req", 64'(is_rd ? bus.sdram_rd_req : bus.sdram_wr_req), 64'd1);
        if (is_rd) begin
            bus.sdram_rd_done = 1'b1;
            bus.sdram_rd_data = rdata;
        end else begin
            bus.sdram_wr_done = 1'b1;
        end
        tick();
        bus.sdram_rd_done = 1'b0;
        bus.sdram_wr_done = 1'b0;
        bus.sdram_rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("done_pulse", 64'(dones()), 64'(exp_d));
        chk("req_drop", 64'({bus.sdram_rd_req, bus.sdram_wr_req}), 64'd0);
        if (is_rd) chk("rd_data", bus.rd_data, rdata);
        tick();
        chk("gap_grant", 64'(bus.grant), 64'd3);
        chk("gap_done", 64'(dones()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 24'd0, 24'd384000, 24'd0, 64'd200, 64'd0,
                    5, 64'd0, 2'd1, 1'b0,1'b1, 24'd384000, 64'd200, 1'b0};
        vecs[1] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 24'h001000, 24'h002000, 24'd0, 64'd0, 64'd0,
                    3, 64'h1111_2222_3333_4444, 2'd0, 1'b1,1'b0, 24'h001000, 64'd0, 1'b0};
        vecs[2] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 24'd0, 24'h000040, 24'h000080, 64'hAAAA, 64'hBBBB,
                    2, 64'h0123_4567_89AB_CDEF, 2'd1, 1'b1,1'b0, 24'h000040, 64'd0, 1'b0};
        vecs[3] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 24'd0, 24'd0, 24'hFFFFFC, 64'd0, 64'hDEAD_BEEF_CAFE_F00D,
                    1, 64'd0, 2'd2, 1'b0,1'b1, 24'hFFFFFC, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
        vecs[4] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 24'd0, 24'd0, 24'd7213, 64'd0, 64'h5555,
                    2, 64'd0, 2'd2, 1'b0,1'b1, 24'd7212, 64'h5555, 1'b1};
        vecs[5] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 24'h000103, 24'd0, 24'd0, 64'd0, 64'd0,
                    2, 64'hFEDC_BA98_7654_3210, 2'd0, 1'b1,1'b0, 24'h000100, 64'd0, 1'b1};
        vecs[6] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 24'd0, 24'd0, 24'h123454, 64'd0, 64'd0,
                    1, 64'h0F0F_F0F0_1234_8765, 2'd2, 1'b1,1'b0, 24'h123454, 64'd0, 1'b0};
        vecs[7] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 24'd0, 24'h000010, 24'd0, 64'h77, 64'd0,
                    1, 64'd0, 2'd1, 1'b0,1'b1, 24'h000010, 64'h77, 1'b1};

        clear_inputs();
        tick();

        for (int v = 0; v < 8; v++) begin
            do_reset();
            chk("rst_grant", 64'(bus.grant), 64'd3);
            chk("rst_req", 64'({bus.sdram_rd_req, bus.sdram_wr_req}), 64'd0);
            chk("rst_err", 64'(bus.err), 64'd0);
            chk("rst_done", 64'(dones()), 64'd0);
            bus.m0_rd_req = vecs[v].m0_rd;  bus.m0_addr = vecs[v].m0_addr;
            bus.m1_rd_req = vecs[v].m1_rd;  bus.m1_wr_req = vecs[v].m1_wr;
            bus.m1_addr = vecs[v].m1_addr;  bus.m1_wr_data = vecs[v].m1_wd;
            bus.m2_rd_req = vecs[v].m2_rd;  bus.m2_wr_req = vecs[v].m2_wr;
            bus.m2_addr = vecs[v].m2_addr;  bus.m2_wr_data = vecs[v].m2_wd;
            tick();
            chk("vec_grant", 64'(bus.grant), 64'(vecs[v].exp_grant));
            chk("vec_rd_req", 64'(bus.sdram_rd_req), 64'(vecs[v].exp_rd));
            chk("vec_wr_req", 64'(bus.sdram_wr_req), 64'(vecs[v].exp_wr));
            chk("vec_addr", 64'(bus.sdram_addr), 64'(vecs[v].exp_addr));
            if (vecs[v].exp_wr) chk("vec_wr_data", bus.sdram_wr_data, vecs[v].exp_wd);
            serve(vecs[v].lat, vecs[v].exp_rd, vecs[v].ctl_rd, vecs[v].exp_grant);
            clear_inputs();
            chk("vec_err", 64'(bus.err), 64'(vecs[v].exp_err));
        end

        // M0 and M1 together: M0 first, then M1 after the gap.
        do_reset();
        bus.m0_rd_req = 1; bus.m0_addr = 24'h000200;
        bus.m1_rd_req = 1; bus.m1_addr = 24'h000300;
        tick();
        chk("seqA_g0", 64'(bus.grant), 64'd0);
        chk("seqA_a0", 64'(bus.sdram_addr), 64'h200);
        serve(3, 1'b1, 64'hA0A0_0000_0000_0001, 2'd0);
        bus.m0_rd_req = 0;
        tick();
        chk("seqA_idle", 64'(bus.grant), 64'd3);
        tick();
        chk("seqA_g1", 64'(bus.grant), 64'd1);
        chk("seqA_a1", 64'(bus.sdram_addr), 64'h300);
        serve(2, 1'b1, 64'hB1B1_0000_0000_0002, 2'd1);
        clear_inputs();

        // M1/M2 continuously requesting alternate, starting with M1.
        do_reset();
        bus.m1_rd_req = 1; bus.m1_addr = 24'h000400;
        bus.m2_rd_req = 1; bus.m2_addr = 24'h000800;
        tick();
        for (int g = 0; g < 6; g++) begin
            logic [1:0] eg;
            eg = (g % 2 == 0) ? 2'd1 : 2'd2;
            chk("rr_grant", 64'(bus.grant), 64'(eg));
            chk("rr_addr", 64'(bus.sdram_addr), (g % 2 == 0) ? 64'h400 : 64'h800);
            serve(2, 1'b1, 64'(g + 100), eg);
            tick();
            tick();
        end
        clear_inputs();

        // Non-matching done is ignored.
        do_reset();
        bus.m1_rd_req = 1; bus.m1_addr = 24'h000020;
        tick();
        bus.sdram_wr_done = 1;
        tick();
        bus.sdram_wr_done = 0;
        chk("ign_req", 64'(bus.sdram_rd_req), 64'd1);
        chk("ign_done", 64'(dones()), 64'd0);
        serve(1, 1'b1, 64'hC0FF_EE00_0000_0003, 2'd1);
        clear_inputs();

        // Error stays set across a clean access, clears on reset.
        do_reset();
        bus.m2_rd_req = 1; bus.m2_wr_req = 1; bus.m2_addr = 24'd7213; bus.m2_wr_data = 64'h9;
        tick();
        chk("stk_addr", 64'(bus.sdram_addr), 64'd7212);
        serve(2, 1'b0, 64'd0, 2'd2);
        clear_inputs();
        bus.m1_wr_req = 1; bus.m1_addr = 24'h000040; bus.m1_wr_data = 64'h1;
        tick();
        tick();
        chk("stk_grant", 64'(bus.grant), 64'd1);
        serve(1, 1'b0, 64'd0, 2'd1);
        clear_inputs();
        chk("stk_err_hold", 64'(bus.err), 64'd1);
        do_reset();
        chk("stk_err_clr", 64'(bus.err), 64'd0);

        // Reset while BUSY drops the request without a done pulse.
        do_reset();
        bus.m1_rd_req = 1; bus.m1_addr = 24'h000060;
        tick();
        chk("mid_busy", 64'(bus.sdram_rd_req), 64'd1);
        rst_n = 0;
        tick();
        rst_n = 1;
        bus.m1_rd_req = 0;
        chk("mid_req", 64'({bus.sdram_rd_req, bus.sdram_wr_req}), 64'd0);
        chk("mid_grant", 64'(bus.grant), 64'd3);
        begin
            logic [2:0] seen;
            seen = dones();
            for (int i = 0; i < 4; i++) begin
                tick();
                seen = seen | dones();
            end
            chk("mid_no_done", 64'(seen), 64'd0);
        end

`ifdef SDRAM_ARB_TIMEOUT_EN
        do_reset();
        bus.m1_rd_req = 1; bus.m1_addr = 24'h000080;
        bus.sdram_rd_data = 64'h1234;
        tick();
        begin
            int cnt;
            cnt = 0;
            while (bus.sdram_rd_req && cnt < 40) begin
                cnt++;
                tick();
            end
            chk("to_cycles", 64'(cnt), 64'd16);
        end
        chk("to_done", 64'(dones()), 64'b010);
        chk("to_rd_data", bus.rd_data, 64'd0);
        chk("to_err", 64'(bus.err), 64'd1);
        clear_inputs();
        tick();
        chk("to_gap", 64'(bus.grant), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
